// File: rtl/rv16_prog_loader.sv
// rv16_prog_loader
// Receives a framed byte stream and writes the enclosed program image into the
// rv16r instruction memory, holding the core in reset until the whole image
// has arrived with a matching checksum.
//
// Frame: SYNC, COUNT_HI, COUNT_LO, 2*COUNT data bytes (high byte of each word
// first), CHK = XOR of all data bytes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   byte source has a byte on in_data
//   in_data    byte-stream data
//   in_ready   loader can accept a byte (transfer when in_valid && in_ready)
//   mem_we     one-cycle write strobe per instruction word
//   mem_addr   word address of the write
//   mem_wdata  instruction word being written
//   cpu_rst    holds the core in reset while high
//   done       image loaded and checksum verified
//   err        last frame was rejected
module rv16_prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [16:0]       count_full;
  logic              count_bad;

  // in_ready comes from a flop, so acceptance never loops back through it.
  assign accept = in_valid && in_ready_q;

  // Full COUNT as it stands once COUNT_LO arrives; one extra bit so the
  // 2**ADDR_W limit can be compared without wrapping.
  assign count_full = {1'b0, count_q[15:8], in_data};
  assign count_bad  = (count_full == 17'd0) || (count_full > (17'd1 << ADDR_W));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (accept) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (in_data == SYNC) state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          count_d[15:8] = in_data;
          state_d       = S_LEN_LO;
        end
        S_LEN_LO: begin
          count_d = count_full[15:0];
          idx_d   = 16'd0;
          chk_d   = 8'd0;
          state_d = count_bad ? S_ERR : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = in_data;
          chk_d   = chk_q ^ in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          // The write is registered, so it appears the cycle after the low byte.
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, in_data};
          chk_d       = chk_q ^ in_data;
          idx_d       = idx_q + 16'd1;
          state_d     = (idx_q == count_q - 16'd1) ? S_CHK : S_DATA_HI;
        end
        S_CHK: begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERR;
        end
        default: state_d = state_q;
      endcase
    end

    // Status outputs follow the next state so they change together with it.
    in_ready_d = (state_d != S_DONE);
    cpu_rst_d  = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      idx_q       <= 16'd0;
      chk_q       <= 8'd0;
      hi_q        <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
      in_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rv16_prog_loader.sv
// tb_rv16_prog_loader
// Drives framed byte streams into rv16_prog_loader and compares memory writes
// and status outputs against a frame-level model of the loader's behaviour.
module tb_rv16_prog_loader;

  localparam int         ADDR_W = 10;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checkCount = 0;
  int errorCount = 0;

  // Expected writes as {addr, data}, consumed in order by the write monitor.
  logic [ADDR_W+15:0] expWrites[$];
  // Words of the frame about to be sent.
  logic [15:0]        frameWords[$];

  rv16_prog_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Watch every cycle for memory writes and the ready/done/cpu_rst relationship.
  always @(negedge clk) begin
    logic [ADDR_W+15:0] w;
    if (rst === 1'b0) begin
      checkOutput("ready_vs_done", {31'd0, in_ready}, {31'd0, ~done});
      checkOutput("cpurst_vs_done", {31'd0, cpu_rst}, {31'd0, ~done});
      if (mem_we === 1'b1) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_we", 32'd1, 32'd0);
        end else begin
          w = expWrites.pop_front();
          checkOutput("we_addr", {22'd0, mem_addr}, {22'd0, w[ADDR_W+15:16]});
          checkOutput("we_data", {16'd0, mem_wdata}, {16'd0, w[15:0]});
        end
      end
    end
  end

  // Offer one byte after an optional random gap and wait until it is taken.
  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    int  gap;
    bit  accepted;
    logic rdy;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    accepted = 1'b0;
    for (int t = 0; t < 32 && !accepted; t++) begin
      if (t > 0) @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      accepted = (rdy === 1'b1);
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cpu_rst"},  {31'd0, cpu_rst},  32'd1);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    checkOutput({tag, "_done"},     {31'd0, done},     32'd0);
    checkOutput({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  // Reset while a SYNC byte is offered; that byte must not be taken.
  task automatic applyReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = SYNC;
    @(negedge clk);
    checkIdleOutputs("in_reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    expWrites.delete();
  endtask

  task automatic fillRandom(input int n);
    frameWords.delete();
    repeat (n) frameWords.push_back(16'($urandom));
  endtask

  // Send a whole frame built from frameWords and check the expected outcome:
  // a rejected count, or every word written in order and then done/err
  // decided by whether the CHK byte equals the XOR of all data bytes.
  task automatic runFrame(input logic [15:0] cnt, input bit forceChk,
                          input logic [7:0] chkByte, input logic [7:0] flip,
                          input int maxGap);
    bit                valid;
    logic [7:0]        x;
    logic [7:0]        c;
    logic [15:0]       w;
    logic [ADDR_W-1:0] a;
    valid = (cnt != 16'd0) && (int'(cnt) <= (1 << ADDR_W));
    applyStimulus(SYNC, maxGap);
    idle(1);
    checkOutput("sync_clears_err", {31'd0, err}, 32'd0);
    applyStimulus(cnt[15:8], maxGap);
    applyStimulus(cnt[7:0], maxGap);
    if (!valid) begin
      idle(1);
      checkOutput("badlen_err",     {31'd0, err},     32'd1);
      checkOutput("badlen_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("badlen_done",    {31'd0, done},    32'd0);
      idle(2);
      checkOutput("badlen_no_we", expWrites.size(), 32'd0);
      return;
    end
    x = 8'd0;
    for (int i = 0; i < int'(cnt); i++) begin
      w = frameWords[i];
      a = i[ADDR_W-1:0];
      expWrites.push_back({a, w});
      applyStimulus(w[15:8], maxGap);
      applyStimulus(w[7:0], maxGap);
      x = x ^ w[15:8] ^ w[7:0];
    end
    c = forceChk ? chkByte : (x ^ flip);
    applyStimulus(c, maxGap);
    idle(1);
    if (c == x) begin
      checkOutput("ok_done",     {31'd0, done},     32'd1);
      checkOutput("ok_cpu_rst",  {31'd0, cpu_rst},  32'd0);
      checkOutput("ok_err",      {31'd0, err},      32'd0);
      checkOutput("ok_in_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      checkOutput("bad_chk_err",     {31'd0, err},     32'd1);
      checkOutput("bad_chk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("bad_chk_done",    {31'd0, done},    32'd0);
    end
    idle(2);
    checkOutput("writes_drained", expWrites.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] cnt;
    logic [7:0]  flip;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(2);

    $display("[TB] reset and idle");
    applyReset();
    repeat (5) begin
      idle(1);
      checkIdleOutputs("idle");
    end

    $display("[TB] two-word frame back-to-back");
    frameWords.delete();
    frameWords.push_back(16'h1234);
    frameWords.push_back(16'hABCD);
    runFrame(16'd2, 1'b1, 8'h40, 8'h00, 0);
    repeat (3) begin
      idle(1);
      checkOutput("done_hold_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("done_hold_done",  {31'd0, done},     32'd1);
    end

    $display("[TB] leading junk then gapped frame");
    applyReset();
    applyStimulus(8'h00, 2);
    applyStimulus(8'hFF, 2);
    applyStimulus(8'h5A, 2);
    idle(1);
    checkIdleOutputs("junk");
    runFrame(16'd2, 1'b1, 8'h40, 8'h00, 3);

    $display("[TB] bad checksum then retry");
    applyReset();
    frameWords.delete();
    frameWords.push_back(16'hBEEF);
    runFrame(16'd1, 1'b1, 8'h00, 8'h00, 0);
    runFrame(16'd1, 1'b1, 8'h51, 8'h00, 0);

    $display("[TB] count limits");
    applyReset();
    runFrame(16'h0000, 1'b0, 8'h00, 8'h00, 0);
    runFrame(16'h0401, 1'b0, 8'h00, 8'h00, 0);
    fillRandom(1024);
    runFrame(16'h0400, 1'b0, 8'h00, 8'h00, 0);

    $display("[TB] reset mid-frame");
    applyReset();
    expWrites.push_back({10'd0, 16'h1122});
    applyStimulus(SYNC, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    idle(2);
    checkOutput("abort_writes", expWrites.size(), 32'd0);
    applyReset();
    idle(1);
    checkIdleOutputs("after_abort");
    fillRandom(3);
    runFrame(16'd3, 1'b0, 8'h00, 8'h00, 2);

    $display("[TB] random frames");
    repeat (8) begin
      applyReset();
      cnt  = 16'($urandom_range(8, 1));
      flip = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      fillRandom(int'(cnt));
      runFrame(cnt, 1'b0, 8'h00, flip, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rv16_prog_loader.md
RV16_PROG_LOADER -- requirements
Module: rv16_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10: instruction memory word-address width (1024 words).
REQ-002 Parameter SYNC, default 8'hA5: frame start byte.
REQ-003 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port in_valid  input  1: byte source has a byte on in_data.
REQ-006 Port in_data  input  8: byte-stream data.
REQ-007 Port in_ready  output  1: loader can accept a byte; a transfer occurs on a clk edge with in_valid and in_ready both high.
REQ-008 Port mem_we  output  1: instruction memory write strobe, one cycle per word.
REQ-009 Port mem_addr  output  ADDR_W: instruction memory word address.
REQ-010 Port mem_wdata  output  16: instruction word to write.
REQ-011 Port cpu_rst  output  1: holds the rv16r core in reset while high.
REQ-012 Port done  output  1: image loaded and verified.
REQ-013 Port err  output  1: last frame was rejected.

Function
REQ-014 Frame format: SYNC, COUNT_HI, COUNT_LO, then 2*COUNT data bytes (each word high byte first), then CHK = XOR of all data bytes.
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR.
REQ-016 IDLE: accepting SYNC moves to LEN_HI; any other accepted byte is discarded.
REQ-017 LEN_HI/LEN_LO: latch the 16-bit COUNT; after LEN_LO, if COUNT == 0 or COUNT > 2**ADDR_W, go to ERR; otherwise go to DATA_HI with word index and checksum cleared to 0.
REQ-018 DATA_HI: latch the byte as bits [15:8]; go to DATA_LO.
REQ-019 DATA_LO: on the accepted byte, in the next cycle drive mem_we=1 for exactly one cycle, mem_wdata={hi,lo}, mem_addr=current word index; then increment the index.
REQ-020 After the word whose index equals COUNT-1, go to CHK; otherwise return to DATA_HI.
REQ-021 Every accepted data byte is XORed into the running checksum; SYNC, COUNT and CHK bytes are not.
REQ-022 CHK: if the accepted byte equals the running checksum, go to DONE; otherwise go to ERR.
REQ-023 DONE: in_ready=0, done=1, cpu_rst=0; the loader stays there until rst.
REQ-024 ERR: err=1, cpu_rst=1, in_ready=1; an accepted SYNC byte clears err and moves to LEN_HI; other bytes are discarded.
REQ-025 in_ready is 1 in every state except DONE; there is no combinational path from in_valid to in_ready.
REQ-026 When in_valid is low, the state, index and checksum hold; gaps between bytes of any length are legal.
REQ-027 cpu_rst is 1 in every state except DONE; it falls in the cycle after the matching CHK byte is accepted, together with done rising.
REQ-028 Words already written before an ERR are left in memory; a restarted frame rewrites from address 0.
REQ-029 mem_addr and mem_wdata are don't-care while mem_we is 0.

Reset
REQ-030 On a clk edge with rst=1, the loader enters IDLE, clears the index, count and checksum, and aborts any frame mid-stream.
REQ-031 During and after reset: cpu_rst=1, in_ready=1, mem_we=0, done=0, err=0.
REQ-032 A byte presented in the reset cycle is not accepted.

Verification
REQ-033 Reset, then idle for 5 cycles -> cpu_rst=1, in_ready=1, mem_we=0, done=0, err=0 throughout.
REQ-034 Send A5 00 02 12 34 AB CD 40 back-to-back -> expect:
  - mem_we pulses with addr 0 / data 1234, then addr 1 / data ABCD;
  - done=1 and cpu_rst=0 one cycle after 40 is accepted;
  - in_ready=0 thereafter.
REQ-035 Send 00 FF 5A, then the frame from REQ-034 with random in_valid gaps -> leading bytes ignored; identical writes and done.
REQ-036 Send A5 00 01 BE EF 00 (bad CHK, expected 51) -> one write (addr 0, data BEEF), then err=1, cpu_rst=1, done=0. Then send A5 00 01 BE EF 51 -> err=0, done=1.
REQ-037 COUNT=0000 and COUNT=0401 -> err=1 immediately after COUNT_LO, no mem_we.
REQ-038 Assert rst after A5 00 03 11 22 -> IDLE, all outputs at reset values. Then a full 3-word frame writes addresses 0..2 and done=1.
